window_fetch: RTL

- Producer side of the 25-word data window (D0..D24) that the decode/execute pipeline register latches each cycle.
- On a start request, reads a 5x5 block of 32-bit words from data memory, one word per cycle.
- Assembles the words in a staging buffer, then publishes all 25 words atomically with a one-cycle done pulse.
- Holds the pipeline stalled for the whole fetch so the pipe register never captures a partially loaded window.

---
 rtl/window_fetch.sv | 102 ++++++++++
 1 files changed

// File: rtl/window_fetch.sv
// Fetches a 5x5 block of words from data memory, one read per cycle, into a
// staging buffer and publishes the whole window at once with a done pulse.
module window_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int WIN    = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [15:0]                 stride,
  output logic                        mem_rd,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy,
  output logic                        done,
  output logic [WIN*WIN*DATA_W-1:0]   window_out,
  output logic [1:0]                  state
);

  // Handshake: start is a level request sampled only when busy=0 or done=1
  // (IDLE/DONE); there is no back-pressure. done is a one-cycle strobe that
  // coincides with the first cycle window_out shows the new window.

  localparam int NW = WIN * WIN;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] COL_LAST = 3'(WIN - 1);
  localparam logic [4:0] IDX_LAST = 5'(NW - 1);

  logic [1:0]        st;
  logic [15:0]       stride_q;
  logic [ADDR_W-1:0] row_base;
  logic [2:0]        col;
  logic [4:0]        idx;
  logic              tag_valid;
  logic [4:0]        tag_idx;
  logic [DATA_W-1:0] staging [NW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st         <= S_IDLE;
      stride_q   <= '0;
      row_base   <= '0;
      col        <= '0;
      idx        <= '0;
      tag_valid  <= 1'b0;
      tag_idx    <= '0;
      window_out <= '0;
      for (int k = 0; k < NW; k++) staging[k] <= '0;
    end else begin
      // Read data returns one cycle after its strobe, so the tag lags by one.
      tag_valid <= (st == S_FETCH);
      tag_idx   <= idx;
      if (tag_valid) staging[tag_idx] <= mem_rdata;

      case (st)
        S_IDLE, S_DONE: begin
          if (start) begin
            stride_q <= stride;
            row_base <= base_addr;
            col      <= '0;
            idx      <= '0;
            st       <= S_FETCH;
          end else begin
            st <= S_IDLE;
          end
        end
        S_FETCH: begin
          idx <= idx + 5'd1;
          if (col == COL_LAST) begin
            col      <= '0;
            row_base <= row_base + ADDR_W'(stride_q);
          end else begin
            col <= col + 3'd1;
          end
          if (idx == IDX_LAST) st <= S_DRAIN;
        end
        S_DRAIN: begin
          // Last word is still on the bus; take it directly alongside staging.
          for (int k = 0; k < NW - 1; k++)
            window_out[k*DATA_W +: DATA_W] <= staging[k];
          window_out[(NW-1)*DATA_W +: DATA_W] <= mem_rdata;
          st <= S_DONE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  assign state    = st;
  assign mem_rd   = (st == S_FETCH);
  assign mem_addr = mem_rd ? (row_base + ADDR_W'(col)) : '0;
  assign busy     = (st != S_IDLE);
  assign done     = (st == S_DONE);

endmodule
